mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles spent waiting for ram_ack before abort (legal range 1-255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low; 0 resets the block immediately, independent of clk.
REQ-004 SHALL have port req, input, 1: CPU access request, sampled only in IDLE.
REQ-005 SHALL have port we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port funct3, input, 3: access size/sign, using the RV32I load/store encoding.
REQ-007 SHALL have port addr, input, 32: byte address (datapath ALU result).
REQ-008 SHALL have port wdata, input, 32: store data (datapath rs2 value).
REQ-009 SHALL have port busy, output, 1: high whenever state != IDLE; the CPU stalls the PC on this signal.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking a successful access.
REQ-011 SHALL have port rdata, output, 32: extended load data, fed to the datapath Data_in.
REQ-012 SHALL have port err, output, 1: one-cycle pulse marking an aborted access.
REQ-013 SHALL have port err_code, output, 2: 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-014 SHALL have port ram_req, output, 1: RAM request, held until ram_ack.
REQ-015 SHALL have port ram_we, output, 1: RAM write enable.
REQ-016 SHALL have port ram_addr, output, 32: word address {addr[31:2],2'b00}.
REQ-017 SHALL have port ram_wmask, output, 4: byte-lane enables.
REQ-018 SHALL have port ram_wdata, output, 32: lane-replicated store data.
REQ-019 SHALL have port ram_ack, input, 1: RAM completion, valid in any cycle while ram_req=1.
REQ-020 SHALL have port ram_rdata, input, 32: read word, valid when ram_ack=1.

Function
REQ-021 SHALL implement the FSM states IDLE, WAIT, RESP, ERR.
REQ-022 IDLE & req=1 SHALL register we, funct3, addr and wdata, then go to WAIT, or to ERR if the request is illegal or misaligned.
REQ-023 Legal load funct3 values SHALL be 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal store values SHALL be 000 SB, 001 SH, 010 SW; any other value SHALL select ERR with err_code 10.
REQ-024 A request SHALL be misaligned when it is a half access with addr[0]=1 or a word access with addr[1:0]!=0; such a request SHALL select ERR with err_code 01, and ram_req SHALL never assert for it.
REQ-025 In WAIT: ram_req=1, and ram_addr, ram_we, ram_wmask and ram_wdata SHALL stay stable until ram_ack.
REQ-026 ram_wmask SHALL be 0001<<addr[1:0] for byte accesses, 0011<<addr[1:0] for half accesses, and 1111 for word accesses; it SHALL be 0000 on loads.
REQ-027 ram_wdata SHALL be {4{wdata[7:0]}} for byte accesses, {2{wdata[15:0]}} for half accesses, and wdata for word accesses.
REQ-028 WAIT & ram_ack=1 SHALL select RESP; a load SHALL latch the byte or half selected by addr[1:0] into rdata, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-029 RESP SHALL assert done=1 for exactly one cycle, then return to IDLE; rdata SHALL hold its value until the next load completes.
REQ-030 An 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle without ack; reaching TIMEOUT SHALL select ERR with err_code 11 and drop ram_req in that same transition.
REQ-031 When ram_ack and timeout occur in the same cycle, ack SHALL win.
REQ-032 ERR SHALL assert err=1 for one cycle with err_code valid, then return to IDLE; err_code SHALL read 00 outside ERR.
REQ-033 req while busy=1 SHALL be ignored and not queued; ram_ack outside WAIT SHALL be ignored.
REQ-034 Minimum latency SHALL be: req sampled at edge N -> ram_req from N -> ack sampled at N+1 -> done high during cycle N+2 to N+3.
REQ-035 done and err SHALL never be high simultaneously.

Reset
REQ-036 rst=0 SHALL immediately force state IDLE and set busy, done, err, ram_req and ram_we to 0, err_code, ram_wmask and counter to 0, and rdata, ram_addr and ram_wdata to 0x00000000.
REQ-037 Reset in WAIT SHALL drop ram_req asynchronously; no done or err pulse SHALL follow.

Verification
REQ-038 LB, addr=0x103, RAM word 0x80FF1234, ack after 2 cycles -> rdata=0xFFFFFF80, one done pulse.
REQ-039 SH, addr=0x202, wdata=0x0000ABCD -> ram_addr=0x200, ram_wmask=1100, ram_wdata=0xABCDABCD, ram_we=1.
REQ-040 LW, addr=0x0006 -> err=1 with err_code=01 and no ram_req cycle.
REQ-041 TIMEOUT=4 with ram_ack held 0 -> ram_req high for 4 cycles, then err_code=11; a late ack is ignored.
REQ-042 rst low mid-WAIT -> ram_req=0 without waiting for a clock edge; after release, a fresh LHU from addr=0x2 of word 0xBEEF0000 -> rdata=0x0000BEEF.
REQ-043 req pulsed during busy -> the second request is dropped, and exactly one done pulse occurs.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit bridging an RV32I core to a single-port word RAM.
// Handles byte/half/word sizing, alignment checks, lane steering and a RAM ack timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_wmask,
    output logic [31:0] ram_wdata,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0]  CODE_MISALIGN = 2'b01;
    localparam logic [1:0]  CODE_ILLEGAL  = 2'b10;
    localparam logic [1:0]  CODE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         lane_q, lane_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         code_q, code_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ram_req_q, ram_req_d;
    logic               ram_we_q, ram_we_d;
    logic [31:0]        ram_addr_q, ram_addr_d;
    logic [3:0]         ram_wmask_q, ram_wmask_d;
    logic [31:0]        ram_wdata_q, ram_wdata_d;

    logic               legal_c;
    logic               misaligned_c;
    logic [3:0]         wmask_c;
    logic [31:0]        wdata_rep_c;
    logic [31:0]        shifted_c;
    logic [31:0]        load_c;

    // Incoming request decode: legality, alignment, lane mask and replicated store data.
    always_comb begin
        legal_c      = we ? (funct3 inside {3'b000, 3'b001, 3'b010})
                          : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned_c = 1'b0;
        wmask_c      = 4'b1111;
        wdata_rep_c  = wdata;
        case (funct3[1:0])
            2'b00: begin
                wmask_c     = 4'b0001 << addr[1:0];
                wdata_rep_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned_c = addr[0];
                wmask_c      = 4'b0011 << addr[1:0];
                wdata_rep_c  = {2{wdata[15:0]}};
            end
            default: misaligned_c = (addr[1:0] != 2'b00);
        endcase
        if (!we) begin
            wmask_c = 4'b0000;
        end
    end

    // Read word steering; a word access always has lane 0 so the shift is a no-op there.
    always_comb begin
        shifted_c = ram_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_c = {24'h000000, shifted_c[7:0]};
            3'b101:  load_c = {16'h0000, shifted_c[15:0]};
            default: load_c = shifted_c;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        rdata_d     = rdata_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wmask_d = ram_wmask_q;
        ram_wdata_d = ram_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = 2'b00;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d   = we;
                    f3_d   = funct3;
                    lane_d = addr[1:0];
                    if (!legal_c) begin
                        code_d  = CODE_ILLEGAL;
                        state_d = ERR;
                    end else if (misaligned_c) begin
                        code_d  = CODE_MISALIGN;
                        state_d = ERR;
                    end else begin
                        cnt_d       = '0;
                        ram_we_d    = we;
                        ram_addr_d  = {addr[31:2], 2'b00};
                        ram_wmask_d = wmask_c;
                        ram_wdata_d = wdata_rep_c;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                // An ack in the final allowed cycle still completes the access.
                if (ram_ack) begin
                    if (!we_q) begin
                        rdata_d = load_c;
                    end
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err_d      = 1'b1;
                err_code_d = code_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ram_req_d = (state_d == WAIT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            cnt_q       <= '0;
            code_q      <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            rdata_q     <= 32'h0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'h0;
            ram_wmask_q <= 4'b0000;
            ram_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            rdata_q     <= rdata_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wmask_q <= ram_wmask_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign rdata     = rdata_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wmask = ram_wmask_q;
    assign ram_wdata = ram_wdata_q;

endmodule
